// File: rtl/psum_collector.sv
// Drain-side collector for the systolic array's right edge: removes the diagonal row skew,
// packs aligned partial sums into one vector per column and queues them for valid/ready readout.
module psum_collector #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned ROWS  = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ROWS*WIDTH-1:0]     in_psum,
   input  logic [ROWS-1:0]           in_valid,
   input  logic [ROWS-1:0]           in_overflow,
   output logic [ROWS*WIDTH-1:0]     out_data,
   output logic                      out_overflow,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [31:0]               vec_count,
   output logic                      overrun,
   output logic                      skew_err
);

   localparam int unsigned PtrW  = $clog2(DEPTH);
   localparam int unsigned CntW  = PtrW + 1;
   localparam int unsigned LaneW = WIDTH + 2;
   localparam int unsigned VecW  = ROWS * WIDTH + 1;
   localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

   // Lane values after de-skew, all referring to the same array column.
   logic [ROWS*WIDTH-1:0] al_data;
   logic [ROWS-1:0]       al_valid;
   logic [ROWS-1:0]       al_ovf;

   // The last row arrives latest, so it is used live without delay.
   assign al_data[(ROWS-1)*WIDTH +: WIDTH] = in_psum[(ROWS-1)*WIDTH +: WIDTH];
   assign al_valid[ROWS-1]                 = in_valid[ROWS-1];
   assign al_ovf[ROWS-1]                   = in_overflow[ROWS-1] & in_valid[ROWS-1];

   for (genvar r = 0; r < int'(ROWS) - 1; r++) begin : g_lane
      localparam int Stages = int'(ROWS) - 1 - r;

      logic [LaneW-1:0] lane_in;
      logic [LaneW-1:0] stage_q [Stages];

      assign lane_in = {in_psum[r*WIDTH +: WIDTH], in_valid[r], in_overflow[r] & in_valid[r]};

      for (genvar s = 0; s < Stages; s++) begin : g_stage
         logic [LaneW-1:0] stage_in;

         if (s == 0) begin : g_first
            assign stage_in = lane_in;
         end else begin : g_next
            assign stage_in = stage_q[s-1];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               stage_q[s] <= '0;
            end else begin
               stage_q[s] <= stage_in;
            end
         end
      end

      assign al_data[r*WIDTH +: WIDTH] = stage_q[Stages-1][LaneW-1:2];
      assign al_valid[r]               = stage_q[Stages-1][1];
      assign al_ovf[r]                 = stage_q[Stages-1][0];
   end

   logic push_req;
   logic mixed;
   logic full;
   logic pop;
   logic push;

   assign push_req = &al_valid;
   assign mixed    = (|al_valid) && !push_req;

   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     vec_count_q, vec_count_d;
   logic            overrun_q, overrun_d;
   logic            skew_err_q, skew_err_d;
   logic [VecW-1:0] mem_q [DEPTH];

   assign full = (count_q == CntFull);
   assign pop  = out_valid && out_ready;
   // A full FIFO still takes the push when the head leaves in the same cycle.
   assign push = push_req && (!full || pop);

   always_comb begin
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      vec_count_d = vec_count_q;
      overrun_d   = overrun_q;
      skew_err_d  = skew_err_q;

      if (push) begin
         wptr_d      = wptr_q + PtrW'(1);
         vec_count_d = vec_count_q + 32'd1;
      end
      if (pop) begin
         rptr_d = rptr_q + PtrW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CntW'(1);
      end
      if (push_req && full && !pop) begin
         overrun_d = 1'b1;
      end
      if (mixed) begin
         skew_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q      <= '0;
         rptr_q      <= '0;
         count_q     <= '0;
         vec_count_q <= '0;
         overrun_q   <= 1'b0;
         skew_err_q  <= 1'b0;
      end else begin
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         vec_count_q <= vec_count_d;
         overrun_q   <= overrun_d;
         skew_err_q  <= skew_err_d;
      end
   end

   // Storage is not reset; the outputs are gated by out_valid instead.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= {|al_ovf, al_data};
      end
   end

   logic [VecW-1:0] head;

   assign head         = mem_q[rptr_q];
   assign out_valid    = (count_q != '0);
   assign out_data     = out_valid ? head[ROWS*WIDTH-1:0] : '0;
   assign out_overflow = out_valid & head[VecW-1];
   assign fifo_count   = count_q;
   assign vec_count    = vec_count_q;
   assign overrun      = overrun_q;
   assign skew_err     = skew_err_q;

endmodule

// File: tb/tb_psum_collector.sv
// Scoreboard bench for psum_collector: directed skewed streams, expected vectors queued at
// issue time and checked by an independent output monitor.
module tb_psum_collector;

   localparam int W     = 16;
   localparam int ROWS  = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [ROWS*W-1:0]   in_psum;
   logic [ROWS-1:0]     in_valid;
   logic [ROWS-1:0]     in_overflow;
   logic [ROWS*W-1:0]   out_data;
   logic                out_overflow;
   logic                out_valid;
   logic                out_ready;
   logic [CW-1:0]       fifo_count;
   logic [31:0]         vec_count;
   logic                overrun;
   logic                skew_err;

   always #5 clk = ~clk;

   psum_collector #(.WIDTH(W), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_psum      (in_psum),
      .in_valid     (in_valid),
      .in_overflow  (in_overflow),
      .out_data     (out_data),
      .out_overflow (out_overflow),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fifo_count   (fifo_count),
      .vec_count    (vec_count),
      .overrun      (overrun),
      .skew_err     (skew_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [ROWS*W:0]   sb [$];
   logic [ROWS*W:0]   exp_mon;
   logic signed [W-1:0] vd [16][ROWS];
   logic              vo [16][ROWS];
   logic              ov_log [32];

   function automatic void check(input string name, input logic [63:0] got,
                                 input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   // Output monitor: every accepted head must match the oldest expected vector.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: got ovf=%0b data=%h expected none",
                     out_overflow, out_data);
         end else begin
            exp_mon = sb.pop_front();
            if ({out_overflow, out_data} !== exp_mon) begin
               n_fail++;
               $display("FAIL output_vector: got ovf=%0b data=%h expected ovf=%0b data=%h",
                        out_overflow, out_data, exp_mon[ROWS*W], exp_mon[ROWS*W-1:0]);
            end
         end
      end
   end

   task automatic set_vec(input int k, input int a0, input int a1, input int a2, input int a3);
      vd[k][0] = W'(a0);
      vd[k][1] = W'(a1);
      vd[k][2] = W'(a2);
      vd[k][3] = W'(a3);
      for (int r = 0; r < ROWS; r++) vo[k][r] = 1'b0;
   endtask

   task automatic push_exp(input int k);
      logic [ROWS*W:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++) begin
         v[r*W +: W] = vd[k][r];
         v[ROWS*W]   = v[ROWS*W] | vo[k][r];
      end
      sb.push_back(v);
   endtask

   // Vector k lane r is driven in cycle k+r; one lane of one vector may be made a cycle late.
   task automatic drive_stream(input int n, input int late_lane, input int late_vec,
                               input int ready_cyc);
      int d;
      for (int c = 0; c < n + ROWS + 1; c++) begin
         in_valid    = '0;
         in_overflow = '0;
         in_psum     = '0;
         if (ready_cyc >= 0) out_ready = (c == ready_cyc);
         for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < n; k++) begin
               d = r + ((r == late_lane && k == late_vec) ? 1 : 0);
               if (k + d == c) begin
                  in_valid[r]        = 1'b1;
                  in_overflow[r]     = vo[k][r];
                  in_psum[r*W +: W]  = vd[k][r];
               end
            end
         end
         @(posedge clk);
         #1;
         ov_log[c] = out_valid;
      end
      in_valid    = '0;
      in_overflow = '0;
      in_psum     = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int i = 0; i < 40 && fifo_count != 0; i++) begin
         @(posedge clk);
         #1;
      end
      check(name, 64'(fifo_count), 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      out_ready   = 1'b0;
      in_psum     = '0;
      in_valid    = '0;
      in_overflow = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_fifo_count", 64'(fifo_count), 64'd0);
      check("rst_vec_count", 64'(vec_count), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_skew_err", 64'(skew_err), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);

      // T1: single aligned vector, 4-cycle latency, one-cycle valid pulse
      out_ready = 1'b1;
      set_vec(0, 14, -3, 100, 7);
      push_exp(0);
      drive_stream(1, -1, -1, -1);
      check("t1_valid_c2", 64'(ov_log[2]), 64'd0);
      check("t1_valid_c3", 64'(ov_log[3]), 64'd1);
      check("t1_valid_c4", 64'(ov_log[4]), 64'd0);
      check("t1_vec_count", 64'(vec_count), 64'd1);
      wait_drain("t1_drain");
      check("t1_sb_empty", 64'(sb.size()), 64'd0);

      // T2: back-pressure, two vectors dropped
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 6; k++) set_vec(k, k*10, k*10+1, k*10+2, k*10+3);
      for (int k = 0; k < 4; k++) push_exp(k);
      drive_stream(6, -1, -1, -1);
      check("t2_fifo_full", 64'(fifo_count), 64'd4);
      check("t2_overrun", 64'(overrun), 64'd1);
      check("t2_vec_count", 64'(vec_count), 64'd4);
      out_ready = 1'b1;
      wait_drain("t2_drain");
      check("t2_sb_empty", 64'(sb.size()), 64'd0);
      check("t2_vec_count_after", 64'(vec_count), 64'd4);

      // T3: push into a full FIFO while the head is popped
      do_reset();
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) set_vec(k, 100+k*10, 101+k*10, 102+k*10, 103+k*10);
      for (int k = 0; k < 4; k++) push_exp(k);
      drive_stream(4, -1, -1, -1);
      check("t3_fifo_full", 64'(fifo_count), 64'd4);
      set_vec(0, -1, -2, -3, -4);
      push_exp(0);
      drive_stream(1, -1, -1, 3);
      check("t3_fifo_stays", 64'(fifo_count), 64'd4);
      check("t3_overrun", 64'(overrun), 64'd0);
      check("t3_vec_count", 64'(vec_count), 64'd5);
      out_ready = 1'b1;
      wait_drain("t3_drain");
      check("t3_sb_empty", 64'(sb.size()), 64'd0);

      // T4: lane 2 one cycle late, then a good vector
      do_reset();
      out_ready = 1'b1;
      set_vec(0, 1, 2, 3, 4);
      drive_stream(1, 2, 0, -1);
      check("t4_skew_err", 64'(skew_err), 64'd1);
      check("t4_fifo_count", 64'(fifo_count), 64'd0);
      check("t4_vec_count", 64'(vec_count), 64'd0);
      set_vec(0, 5, 6, 7, 8);
      push_exp(0);
      drive_stream(1, -1, -1, -1);
      wait_drain("t4_drain");
      check("t4_vec_count_after", 64'(vec_count), 64'd1);
      check("t4_skew_sticky", 64'(skew_err), 64'd1);
      check("t4_sb_empty", 64'(sb.size()), 64'd0);

      // T5: overflow tag on vector 0 only
      do_reset();
      out_ready = 1'b1;
      set_vec(0, 9, -9, 9, -9);
      vo[0][1] = 1'b1;
      set_vec(1, 1, 1, 1, 1);
      push_exp(0);
      push_exp(1);
      drive_stream(2, -1, -1, -1);
      wait_drain("t5_drain");
      check("t5_sb_empty", 64'(sb.size()), 64'd0);

      // T6: reset with two entries queued and a vector half-way through de-skew
      do_reset();
      out_ready = 1'b0;
      set_vec(0, 3, 3, 3, 3);
      drive_stream(1, 1, 0, -1);
      check("t6_pre_skew_err", 64'(skew_err), 64'd1);
      set_vec(0, 20, 21, 22, 23);
      set_vec(1, 30, 31, 32, 33);
      drive_stream(2, -1, -1, -1);
      check("t6_pre_fifo_count", 64'(fifo_count), 64'd2);
      in_valid = 4'b0001;
      in_psum  = '0;
      in_psum[0 +: W] = 16'd11;
      @(posedge clk);
      #1;
      in_valid = 4'b0010;
      in_psum  = '0;
      in_psum[W +: W] = 16'd22;
      @(posedge clk);
      #1;
      in_valid = '0;
      in_psum  = '0;
      do_reset();
      check("t6_out_valid", 64'(out_valid), 64'd0);
      check("t6_fifo_count", 64'(fifo_count), 64'd0);
      check("t6_vec_count", 64'(vec_count), 64'd0);
      check("t6_overrun", 64'(overrun), 64'd0);
      check("t6_skew_err", 64'(skew_err), 64'd0);
      check("t6_out_data", 64'(out_data), 64'd0);
      in_valid = 4'b0100;
      in_psum[2*W +: W] = 16'd33;
      @(posedge clk);
      #1;
      in_valid = 4'b1000;
      in_psum  = '0;
      in_psum[3*W +: W] = 16'd44;
      @(posedge clk);
      #1;
      in_valid = '0;
      in_psum  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("t6_post_skew_err", 64'(skew_err), 64'd1);
      check("t6_post_fifo_count", 64'(fifo_count), 64'd0);
      check("t6_post_vec_count", 64'(vec_count), 64'd0);
      check("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
